team_select_ctrl: RTL and testbench
===================================

Name: team_select_ctrl

Overview:
- Sequences the team-selection screen: turns raw keyboard keycodes into per-frame key events, moves the 8-entry chooser cursor, and commits picks into a 3-slot team.
- Raises `done_select` once the team is confirmed.
- Sits between the keyboard/frame-timing inputs and the game-state FSM; its outputs drive the chooser-box overlay and the Start→Roam transition.

Parameters:
- `TEAM_SIZE`, 3, number of team slots (`num_chosen` width fixed at 2 bits).
- `REPEAT_DELAY`, 20, frame ticks a movement key must be held before auto-repeat starts.
- `REPEAT_RATE`, 6, frame ticks between auto-repeat events.
- `KEY_W`/`KEY_A`/`KEY_S`/`KEY_D`, 8'h1A/8'h04/8'h16/8'h07, movement keycodes.
- `KEY_ENTER`, 8'h28, commit/confirm keycode.
- `KEY_BKSP`, 8'h2A, undo keycode.

Ports:
- `Clk`  in  1  system clock
- `Reset`  in  1  asynchronous, active-low reset
- `frame_clk`  in  1  vertical-sync frame clock, asynchronous to `Clk`
- `keycode`  in  8  current USB keycode, 0 = no key
- `enable`  in  1  high while the game FSM is in Start
- `cur_choice`  out  3  cursor index 0-7 (row = bit2, column = bits1:0)
- `team`  out  9  slot k at [3k+2:3k], holds the sprite index
- `num_chosen`  out  2  number of filled slots
- `done_select`  out  1  team confirmed
- `confirm_pulse`  out  1  one-Clk pulse on confirmation
- `chooser_active`  out  1  cursor box should be drawn (state PICK or FULL)

Behaviour:
- Reset (Reset=0, async): state=IDLE, cur_choice=0, team=0, num_chosen=0, done_select=0, confirm_pulse=0, key_prev=0, repeat counter=0.
- Frame tick:
  - `frame_clk` passes through a 2-flop synchroniser, then a rising-edge register.
  - `frame_tick` is a 1-Clk pulse, 3 Clk cycles after the `frame_clk` rise.
  - All key decoding happens only on `frame_tick`; all resulting register updates take effect on that same Clk edge.
- Key events, evaluated at `frame_tick`:
  - Press: keycode≠0 and keycode≠key_prev. This loads key_prev=keycode and clears the repeat counter.
  - Hold, movement keys only: keycode==key_prev≠0 increments the repeat counter. An event fires when the counter reaches `REPEAT_DELAY`; the counter then reloads to `REPEAT_DELAY-REPEAT_RATE`.
  - ENTER and BKSP never repeat.
  - keycode==0 clears key_prev and the counter.
  - Unmapped keycodes produce no event but still update key_prev.
  - At most one event per tick.
- FSM states: IDLE, PICK, FULL, DONE.
  - Any state with enable=0: go to IDLE next Clk; team and num_chosen are retained; done_select clears.
  - IDLE→PICK when enable=1. On entry, team=0, num_chosen=0, cur_choice=0.
  - PICK, ENTER: team[num_chosen]=cur_choice; num_chosen+1. If the new value equals `TEAM_SIZE`, go to FULL.
  - PICK, BKSP: if num_chosen>0, decrement num_chosen and zero the vacated slot. If num_chosen=0, ignore.
  - PICK, movement keys:
    - W or S: cur_choice[2] toggles (row swap; both wrap).
    - A: column−1, wrapping 0→3 within the row.
    - D: column+1, wrapping 3→0 within the row.
    - The row bit is unchanged by A/D.
  - FULL:
    - Movement is ignored.
    - ENTER → DONE, with done_select=1 and confirm_pulse=1 for exactly one Clk.
    - BKSP → PICK, num_chosen=2, slot 2 zeroed.
  - DONE:
    - All keys are ignored.
    - done_select is held at 1 until enable=0.
- Repeats: duplicate team members are allowed.
- Outputs: `chooser_active` is combinational from state; all other outputs are registered.
- Reset asserted mid-pick: immediate clear to reset values, no pulse emitted.

Decomposition:
- Package `poke_pkg`:
  - state enum `sel_state_t`
  - keycode constants (W/A/S/D/ENTER/BKSP)
  - `TEAM_SIZE`
  - grid constants (4 columns, 2 rows)
- Sub-module `key_event_gen`: synchroniser, frame-tick edge detect, press/auto-repeat logic.
  - Outputs: one-hot event strobes (up/down/left/right/enter/bksp).
  - `team_select_ctrl` instantiates it and contains only the FSM and the cursor/team datapath.

Test Plan:
- Reset, enable=1, tap D four times (one frame each, release between taps) → cur_choice 1,2,3,0. Then tap S → 4. Then tap A → 7.
- Hold D for 32 frames → event at the press frame, next event at tick 20 after the press, then one event every 6 ticks (3 events total); final cur_choice=3.
- Select at cursors 5, 5, 2 with ENTER → team=9'b010_101_101, num_chosen=3, state FULL. Next ENTER → done_select=1, confirm_pulse high exactly 1 Clk.
- In FULL press BKSP → num_chosen=2, slot2=0, chooser_active=1. BKSP with num_chosen=0 → no change.
- keycode changes mid-frame without a frame_clk edge → no cursor change. frame_clk rise → cur_choice updates 3 Clk later.
- Assert Reset low between two ENTERs, asynchronously mid-cycle → all outputs 0 immediately. Drop enable in DONE → done_select=0, state IDLE next Clk.

Source files
------------

// File: rtl/poke_pkg.sv
// Shared types and constants for the team-selection screen.
package poke_pkg;

    // Team and chooser-grid geometry
    localparam int TEAM_SIZE = 3;
    localparam int GRID_COLS = 4;
    localparam int GRID_ROWS = 2;
    localparam int COL_W     = $clog2(GRID_COLS);
    localparam int CHOICE_W  = $clog2(GRID_COLS * GRID_ROWS);
    localparam int SLOT_W    = CHOICE_W;
    localparam int TEAM_W    = TEAM_SIZE * SLOT_W;

    // USB HID keycodes the screen reacts to
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } sel_state_t;

    // Only cursor-movement keys auto-repeat while held
    function automatic logic is_move_key(input logic [7:0] kc);
        return (kc == KEY_W) || (kc == KEY_A) || (kc == KEY_S) || (kc == KEY_D);
    endfunction

    // Return the team vector with slot idx replaced by val
    function automatic logic [TEAM_W-1:0] set_slot(input logic [TEAM_W-1:0] t,
                                                   input logic [1:0]        idx,
                                                   input logic [SLOT_W-1:0] val);
        logic [TEAM_W-1:0] r;
        r = t;
        for (int k = 0; k < TEAM_SIZE; k++) begin
            if (idx == 2'(k)) begin
                r[k*SLOT_W +: SLOT_W] = val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_event_gen.sv
// Turns raw keycodes into per-frame one-hot key events with auto-repeat.
// Events are combinational and valid only on the frame-tick cycle, so the
// consumer's registers update on the same edge as the key-state registers.
module key_event_gen
    import poke_pkg::*;
#(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       ev_up,
    output logic       ev_down,
    output logic       ev_left,
    output logic       ev_right,
    output logic       ev_enter,
    output logic       ev_bksp
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

    logic             fsync1_q;
    logic             fsync2_q;
    logic             fprev_q;
    logic             frame_tick;
    logic [7:0]       key_prev_q;
    logic [7:0]       key_prev_d;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             fire;

    // frame_clk is foreign to clk: two-flop synchroniser plus edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync1_q <= 1'b0;
            fsync2_q <= 1'b0;
            fprev_q  <= 1'b0;
        end else begin
            fsync1_q <= frame_clk;
            fsync2_q <= fsync1_q;
            fprev_q  <= fsync2_q;
        end
    end

    assign frame_tick = fsync2_q & ~fprev_q;

    // Key-state registers: last seen keycode and the hold/repeat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev_q <= 8'h00;
            rpt_cnt_q  <= '0;
        end else begin
            key_prev_q <= key_prev_d;
            rpt_cnt_q  <= rpt_cnt_d;
        end
    end

    // Press / hold / release classification, evaluated once per frame
    always_comb begin
        key_prev_d = key_prev_q;
        rpt_cnt_d  = rpt_cnt_q;
        fire       = 1'b0;
        cnt_inc    = rpt_cnt_q + CNT_W'(1);
        if (frame_tick) begin
            if (keycode == 8'h00) begin
                key_prev_d = 8'h00;
                rpt_cnt_d  = '0;
            end else if (keycode != key_prev_q) begin
                key_prev_d = keycode;
                rpt_cnt_d  = '0;
                fire       = 1'b1;
            end else if (is_move_key(keycode)) begin
                if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
                    fire      = 1'b1;
                    rpt_cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
                end else begin
                    rpt_cnt_d = cnt_inc;
                end
            end
        end
    end

    // One-hot decode; unmapped keycodes fire nothing
    always_comb begin
        ev_up    = fire && (keycode == KEY_W);
        ev_down  = fire && (keycode == KEY_S);
        ev_left  = fire && (keycode == KEY_A);
        ev_right = fire && (keycode == KEY_D);
        ev_enter = fire && (keycode == KEY_ENTER);
        ev_bksp  = fire && (keycode == KEY_BKSP);
    end

endmodule

// File: rtl/team_select_ctrl.sv
// Team-selection screen controller: chooser cursor, 3-slot team, confirmation.
module team_select_ctrl
    import poke_pkg::*;
#(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic [7:0]          keycode,
    input  logic                enable,
    output logic [CHOICE_W-1:0] cur_choice,
    output logic [TEAM_W-1:0]   team,
    output logic [1:0]          num_chosen,
    output logic                done_select,
    output logic                confirm_pulse,
    output logic                chooser_active
);

    logic ev_up, ev_down, ev_left, ev_right, ev_enter, ev_bksp;

    sel_state_t          state_q, state_d;
    logic [CHOICE_W-1:0] cur_choice_q, cur_choice_d;
    logic [TEAM_W-1:0]   team_q, team_d;
    logic [1:0]          num_chosen_q, num_chosen_d;
    logic                done_select_q, done_select_d;
    logic                confirm_pulse_q, confirm_pulse_d;
    logic [CHOICE_W-1:0] cur_moved;
    logic [COL_W-1:0]    move_col;
    logic                move_row;
    logic [1:0]          num_inc;
    logic [1:0]          num_dec;

    key_event_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_keys (
        .clk       (Clk),
        .rst_n     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .ev_up     (ev_up),
        .ev_down   (ev_down),
        .ev_left   (ev_left),
        .ev_right  (ev_right),
        .ev_enter  (ev_enter),
        .ev_bksp   (ev_bksp)
    );

    // Cursor after a movement event: W/S swap rows, A/D wrap within the row
    always_comb begin
        move_row = cur_choice_q[CHOICE_W-1];
        move_col = cur_choice_q[COL_W-1:0];
        if (ev_up || ev_down) begin
            move_row = ~move_row;
        end else if (ev_left) begin
            move_col = move_col - COL_W'(1);
        end else if (ev_right) begin
            move_col = move_col + COL_W'(1);
        end
        cur_moved = {move_row, move_col};
    end

    assign num_inc = num_chosen_q + 2'd1;
    assign num_dec = num_chosen_q - 2'd1;

    // Next-state and datapath updates for the selection FSM
    always_comb begin
        state_d         = state_q;
        cur_choice_d    = cur_choice_q;
        team_d          = team_q;
        num_chosen_d    = num_chosen_q;
        done_select_d   = done_select_q;
        confirm_pulse_d = 1'b0;
        if (!enable) begin
            state_d       = IDLE;
            done_select_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = PICK;
                    team_d       = '0;
                    num_chosen_d = 2'd0;
                    cur_choice_d = '0;
                end
                PICK: begin
                    if (ev_enter) begin
                        team_d       = set_slot(team_q, num_chosen_q, cur_choice_q);
                        num_chosen_d = num_inc;
                        if (num_inc == 2'(TEAM_SIZE)) begin
                            state_d = FULL;
                        end
                    end else if (ev_bksp) begin
                        if (num_chosen_q != 2'd0) begin
                            num_chosen_d = num_dec;
                            team_d       = set_slot(team_q, num_dec, '0);
                        end
                    end else begin
                        cur_choice_d = cur_moved;
                    end
                end
                FULL: begin
                    if (ev_enter) begin
                        state_d         = DONE;
                        done_select_d   = 1'b1;
                        confirm_pulse_d = 1'b1;
                    end else if (ev_bksp) begin
                        state_d      = PICK;
                        num_chosen_d = 2'(TEAM_SIZE - 1);
                        team_d       = set_slot(team_q, 2'(TEAM_SIZE - 1), '0);
                    end
                end
                DONE: begin
                    done_select_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= IDLE;
            cur_choice_q    <= '0;
            team_q          <= '0;
            num_chosen_q    <= 2'd0;
            done_select_q   <= 1'b0;
            confirm_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_choice_q    <= cur_choice_d;
            team_q          <= team_d;
            num_chosen_q    <= num_chosen_d;
            done_select_q   <= done_select_d;
            confirm_pulse_q <= confirm_pulse_d;
        end
    end

    assign cur_choice     = cur_choice_q;
    assign team           = team_q;
    assign num_chosen     = num_chosen_q;
    assign done_select    = done_select_q;
    assign confirm_pulse  = confirm_pulse_q;
    assign chooser_active = (state_q == PICK) || (state_q == FULL);

endmodule

// File: tb/tb_team_select_ctrl.sv
// Scoreboard bench for team_select_ctrl: expected outputs are queued as each
// frame of stimulus is driven and popped once the frame has been processed.
module tb_team_select_ctrl;
    import poke_pkg::*;

    localparam logic [7:0] KEY_NONE = 8'h00;

    typedef struct packed {
        logic [2:0] cur;
        logic [8:0] slots;
        logic [1:0] num;
        logic       done;
        logic       act;
        logic [1:0] pulses;
    } exp_t;

    typedef struct packed {
        logic [7:0] kc;
        exp_t       e;
    } step_t;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       enable;
    logic [2:0] cur_choice;
    logic [8:0] team;
    logic [1:0] num_chosen;
    logic       done_select;
    logic       confirm_pulse;
    logic       chooser_active;

    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t exp_q[$];

    team_select_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .keycode        (keycode),
        .enable         (enable),
        .cur_choice     (cur_choice),
        .team           (team),
        .num_chosen     (num_chosen),
        .done_select    (done_select),
        .confirm_pulse  (confirm_pulse),
        .chooser_active (chooser_active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk_exp(int c, int t, int n, int d, int a, int p);
        exp_t e;
        e.cur    = 3'(c);
        e.slots  = 9'(t);
        e.num    = 2'(n);
        e.done   = 1'(d);
        e.act    = 1'(a);
        e.pulses = 2'(p);
        return e;
    endfunction

    function automatic step_t mk_step(logic [7:0] kc, int c, int t, int n, int d, int a, int p);
        step_t s;
        s.kc = kc;
        s.e  = mk_exp(c, t, n, d, a, p);
        return s;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.cur    = cur_choice;
        e.slots  = team;
        e.num    = num_chosen;
        e.done   = done_select;
        e.act    = chooser_active;
        e.pulses = {1'b0, confirm_pulse};
        return e;
    endfunction

    task automatic show_fail(input string tag, input int idx, input exp_t got, input exp_t want);
        $display("FAIL %s[%0d]: got cur=%0d team=%b num=%0d done=%b act=%b pulses=%0d, want cur=%0d team=%b num=%0d done=%b act=%b pulses=%0d",
                 tag, idx, got.cur, got.slots, got.num, got.done, got.act, got.pulses,
                 want.cur, want.slots, want.num, want.done, want.act, want.pulses);
    endtask

    task automatic show_ok(input string tag, input int idx, input logic [7:0] kc, input exp_t got);
        $display("ok   %s[%0d] key=%h cur=%0d team=%b num=%0d done=%b act=%b pulses=%0d",
                 tag, idx, kc, got.cur, got.slots, got.num, got.done, got.act, got.pulses);
    endtask

    // One frame: hold kc, pulse frame_clk, count confirm pulses, sample the result
    task automatic run_frame(input logic [7:0] kc, output exp_t obs);
        int pulses;
        pulses = 0;
        @(posedge Clk); #1;
        keycode   = kc;
        frame_clk = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge Clk); #1;
            if (confirm_pulse) pulses++;
            if (c == 2) frame_clk = 1'b0;
        end
        obs = snap();
        obs.pulses = (pulses > 3) ? 2'd3 : 2'(pulses);
    endtask

    task automatic test_reset();
        exp_t got;
        Reset = 1'b0; enable = 1'b0; keycode = KEY_NONE; frame_clk = 1'b0;
        #23;
        got = snap(); n_asserts++;
        if (got !== mk_exp(0, 0, 0, 0, 0, 0)) begin n_fail++; show_fail("reset", 0, got, mk_exp(0, 0, 0, 0, 0, 0)); end
        else show_ok("reset", 0, keycode, got);
        @(negedge Clk); Reset = 1'b1; enable = 1'b1;
        @(posedge Clk); #1;
        got = snap(); n_asserts++;
        if (got !== mk_exp(0, 0, 0, 0, 1, 0)) begin n_fail++; show_fail("enter_pick", 0, got, mk_exp(0, 0, 0, 0, 1, 0)); end
        else show_ok("enter_pick", 0, keycode, got);
    endtask

    task automatic test_cursor_taps();
        step_t plan[$];
        exp_t  obs, e;
        plan.push_back(mk_step(KEY_D, 1, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 1, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 2, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 3, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 3, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 0, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 0, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_S, 4, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 4, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_A, 7, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 7, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_W, 3, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 3, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(8'h55, 3, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 3, 0, 0, 0, 1, 0));
        foreach (plan[i]) begin
            exp_q.push_back(plan[i].e);
            run_frame(plan[i].kc, obs);
            e = exp_q.pop_front(); n_asserts++;
            if (obs !== e) begin n_fail++; show_fail("taps", i, obs, e); end
            else show_ok("taps", i, plan[i].kc, obs);
        end
    endtask

    task automatic test_hold_repeat();
        step_t plan[$];
        exp_t  obs, e;
        // Re-entering PICK through IDLE resets the cursor
        @(posedge Clk); #1; enable = 1'b0;
        @(posedge Clk); #1; enable = 1'b1;
        @(posedge Clk); #1;
        obs = snap(); n_asserts++;
        if (obs !== mk_exp(0, 0, 0, 0, 1, 0)) begin n_fail++; show_fail("reenter", 0, obs, mk_exp(0, 0, 0, 0, 1, 0)); end
        else show_ok("reenter", 0, keycode, obs);
        for (int i = 0; i < 32; i++)
            plan.push_back(mk_step(KEY_D, (i < 20) ? 1 : ((i < 26) ? 2 : 3), 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_NONE, 3, 0, 0, 0, 1, 0));
        foreach (plan[i]) begin
            exp_q.push_back(plan[i].e);
            run_frame(plan[i].kc, obs);
            e = exp_q.pop_front(); n_asserts++;
            if (obs !== e) begin n_fail++; show_fail("hold_d", i, obs, e); end
            else show_ok("hold_d", i, plan[i].kc, obs);
        end
    endtask

    task automatic test_select();
        step_t plan[$];
        exp_t  obs, e;
        plan.push_back(mk_step(KEY_S, 7, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 7, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 4, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 4, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 5, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 5, 0, 0, 0, 1, 0));
        // Held ENTER must commit exactly once
        for (int i = 0; i < 22; i++) plan.push_back(mk_step(KEY_ENTER, 5, 5, 1, 0, 1, 0));
        plan.push_back(mk_step(KEY_NONE, 5, 5, 1, 0, 1, 0));
        plan.push_back(mk_step(KEY_ENTER, 5, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 5, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_W, 1, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 1, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 2, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_ENTER, 2, 173, 3, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 2, 173, 3, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 0, 1, 0));
        foreach (plan[i]) begin
            exp_q.push_back(plan[i].e);
            run_frame(plan[i].kc, obs);
            e = exp_q.pop_front(); n_asserts++;
            if (obs !== e) begin n_fail++; show_fail("select", i, obs, e); end
            else show_ok("select", i, plan[i].kc, obs);
        end
    endtask

    task automatic test_backspace();
        step_t plan[$];
        exp_t  obs, e;
        plan.push_back(mk_step(KEY_BKSP, 2, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_BKSP, 2, 5, 1, 0, 1, 0));  plan.push_back(mk_step(KEY_NONE, 2, 5, 1, 0, 1, 0));
        plan.push_back(mk_step(KEY_BKSP, 2, 0, 0, 0, 1, 0));  plan.push_back(mk_step(KEY_NONE, 2, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_BKSP, 2, 0, 0, 0, 1, 0));  plan.push_back(mk_step(KEY_NONE, 2, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_S, 6, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 6, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_A, 5, 0, 0, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 5, 0, 0, 0, 1, 0));
        plan.push_back(mk_step(KEY_ENTER, 5, 5, 1, 0, 1, 0));  plan.push_back(mk_step(KEY_NONE, 5, 5, 1, 0, 1, 0));
        plan.push_back(mk_step(KEY_ENTER, 5, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 5, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_W, 1, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 1, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_D, 2, 45, 2, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 45, 2, 0, 1, 0));
        plan.push_back(mk_step(KEY_ENTER, 2, 173, 3, 0, 1, 0)); plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 0, 1, 0));
        foreach (plan[i]) begin
            exp_q.push_back(plan[i].e);
            run_frame(plan[i].kc, obs);
            e = exp_q.pop_front(); n_asserts++;
            if (obs !== e) begin n_fail++; show_fail("bksp", i, obs, e); end
            else show_ok("bksp", i, plan[i].kc, obs);
        end
    endtask

    task automatic test_confirm();
        step_t plan[$];
        exp_t  obs, e;
        plan.push_back(mk_step(KEY_ENTER, 2, 173, 3, 1, 0, 1)); plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 1, 0, 0));
        plan.push_back(mk_step(KEY_D, 2, 173, 3, 1, 0, 0));     plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 1, 0, 0));
        plan.push_back(mk_step(KEY_BKSP, 2, 173, 3, 1, 0, 0));  plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 1, 0, 0));
        plan.push_back(mk_step(KEY_ENTER, 2, 173, 3, 1, 0, 0)); plan.push_back(mk_step(KEY_NONE, 2, 173, 3, 1, 0, 0));
        foreach (plan[i]) begin
            exp_q.push_back(plan[i].e);
            run_frame(plan[i].kc, obs);
            e = exp_q.pop_front(); n_asserts++;
            if (obs !== e) begin n_fail++; show_fail("confirm", i, obs, e); end
            else show_ok("confirm", i, plan[i].kc, obs);
        end
    endtask

    task automatic test_enable_drop();
        exp_t got;
        @(posedge Clk); #1; enable = 1'b0;
        @(posedge Clk); #1;
        got = snap(); n_asserts++;
        if (got !== mk_exp(2, 173, 3, 0, 0, 0)) begin n_fail++; show_fail("disable", 0, got, mk_exp(2, 173, 3, 0, 0, 0)); end
        else show_ok("disable", 0, keycode, got);
        enable = 1'b1;
        @(posedge Clk); #1;
        got = snap(); n_asserts++;
        if (got !== mk_exp(0, 0, 0, 0, 1, 0)) begin n_fail++; show_fail("reenable", 0, got, mk_exp(0, 0, 0, 0, 1, 0)); end
        else show_ok("reenable", 0, keycode, got);
    endtask

    task automatic test_midframe_key();
        exp_t got, e;
        @(posedge Clk); #1; keycode = KEY_D;
        repeat (10) @(posedge Clk);
        #1; got = snap(); n_asserts++;
        if (got !== mk_exp(0, 0, 0, 0, 1, 0)) begin n_fail++; show_fail("no_tick", 0, got, mk_exp(0, 0, 0, 0, 1, 0)); end
        else show_ok("no_tick", 0, keycode, got);
        frame_clk = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge Clk); #1;
            e = mk_exp((c == 3) ? 1 : 0, 0, 0, 0, 1, 0);
            got = snap(); n_asserts++;
            if (got !== e) begin n_fail++; show_fail("latency", c, got, e); end
            else show_ok("latency", c, keycode, got);
        end
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        exp_q.push_back(mk_exp(1, 0, 0, 0, 1, 0));
        run_frame(KEY_NONE, got);
        e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; show_fail("latency_release", 0, got, e); end
        else show_ok("latency_release", 0, KEY_NONE, got);
    endtask

    task automatic test_async_reset();
        exp_t got, e;
        exp_q.push_back(mk_exp(1, 1, 1, 0, 1, 0));
        run_frame(KEY_ENTER, got);
        e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; show_fail("pre_reset", 0, got, e); end
        else show_ok("pre_reset", 0, KEY_ENTER, got);
        run_frame(KEY_NONE, got);
        @(posedge Clk); #3; Reset = 1'b0;
        #1;
        got = snap(); n_asserts++;
        if (got !== mk_exp(0, 0, 0, 0, 0, 0)) begin n_fail++; show_fail("async_reset", 0, got, mk_exp(0, 0, 0, 0, 0, 0)); end
        else show_ok("async_reset", 0, keycode, got);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        got = snap(); n_asserts++;
        if (got !== mk_exp(0, 0, 0, 0, 1, 0)) begin n_fail++; show_fail("post_reset", 0, got, mk_exp(0, 0, 0, 0, 1, 0)); end
        else show_ok("post_reset", 0, keycode, got);
    endtask

    initial begin
        test_reset();
        test_cursor_taps();
        test_hold_repeat();
        test_select();
        test_backspace();
        test_confirm();
        test_enable_drop();
        test_midframe_key();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
